// File: rtl/btn_debounce.sv
// btn_debounce: conditions raw push-button inputs for the stopwatch controls.
// Each bit is an independent channel: a 2-FF synchronizer, a debounce
// counter, a clean level output and one-cycle press/release pulses.
// Optional long-press pulse is built when BTN_DEBOUNCE_LONG_EN is defined;
// otherwise btn_l is tied to 0.
module btn_debounce #(
  parameter int BW  = 2,
  parameter int DBN = 240_000,
  parameter int LNG = 24_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] btn_i,
  output logic [BW-1:0] btn_o,
  output logic [BW-1:0] btn_p,
  output logic [BW-1:0] btn_r,
  output logic [BW-1:0] btn_l
);

  localparam int CW = $clog2(DBN);
  localparam logic [CW-1:0] CNT_TOP = CW'(DBN - 1);

  logic [BW-1:0] sync_p0;
  logic [BW-1:0] sync_p1;
  logic [CW-1:0] cnt [BW];

  // Stage 0/1: two-flop synchronizer; nothing else looks at btn_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_i;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debounce; any mismatch shorter than DBN cycles clears the count,
  // and the level plus its edge pulse are registered on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_o <= '0;
      btn_p <= '0;
      btn_r <= '0;
      for (int i = 0; i < BW; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BW; i++) begin
        btn_p[i] <= 1'b0;
        btn_r[i] <= 1'b0;
        if (sync_p1[i] == btn_o[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TOP) begin
          btn_o[i] <= sync_p1[i];
          btn_p[i] <= sync_p1[i];
          btn_r[i] <= ~sync_p1[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_DEBOUNCE_LONG_EN
  localparam int LW = $clog2(LNG + 1);
  localparam logic [LW-1:0] LNG_TOP = LW'(LNG);
  localparam logic [LW-1:0] LNG_PRE = LW'(LNG - 1);

  logic [LW-1:0] lcnt [BW];

  // Stage 3: long-press timer; saturating at LNG makes the pulse fire once
  // per press, and a release (btn_o low) re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_l <= '0;
      for (int i = 0; i < BW; i++) lcnt[i] <= '0;
    end else begin
      for (int i = 0; i < BW; i++) begin
        btn_l[i] <= btn_o[i] && (lcnt[i] == LNG_PRE);
        if (!btn_o[i]) begin
          lcnt[i] <= '0;
        end else if (lcnt[i] != LNG_TOP) begin
          lcnt[i] <= lcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign btn_l = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (DBN=4, LNG=20, BW=2): directed
// scenarios followed by randomized button activity, compared every cycle
// against a window-based reference model.
module tb_btn_debounce;

  localparam int BW  = 2;
  localparam int DBN = 4;
  localparam int LNG = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] btn_i = '0;
  logic [BW-1:0] btn_o;
  logic [BW-1:0] btn_p;
  logic [BW-1:0] btn_r;
  logic [BW-1:0] btn_l;

  always #5 clk = ~clk;

  btn_debounce #(.BW(BW), .DBN(DBN), .LNG(LNG)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_i),
    .btn_o (btn_o),
    .btn_p (btn_p),
    .btn_r (btn_r),
    .btn_l (btn_l)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: history of raw samples and synchronized values.
  logic [BW-1:0] raw_q[$];
  logic [BW-1:0] s_q[$];
  logic [BW-1:0] exp_o = '0;
  logic [BW-1:0] exp_p = '0;
  logic [BW-1:0] exp_r = '0;
  logic [BW-1:0] exp_l = '0;
  int            since_p [BW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The level flips once the last DBN synchronized samples all disagree with it.
  task automatic model_step(input logic r, input logic [BW-1:0] b);
    logic [BW-1:0] s;
    logic [BW-1:0] prev;
    logic          stable;
    if (r) begin
      raw_q.delete();
      s_q.delete();
      exp_o = '0; exp_p = '0; exp_r = '0; exp_l = '0;
      for (int i = 0; i < BW; i++) since_p[i] = 0;
      return;
    end
    raw_q.push_back(b);
    if (raw_q.size() > 8) void'(raw_q.pop_front());
    s = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : '0;
    s_q.push_back(s);
    if (s_q.size() > 8) void'(s_q.pop_front());
    prev  = exp_o;
    exp_p = '0;
    exp_r = '0;
    exp_l = '0;
    for (int i = 0; i < BW; i++) begin
`ifdef BTN_DEBOUNCE_LONG_EN
      if (prev[i]) begin
        if (since_p[i] <= LNG) since_p[i]++;
        if (since_p[i] == LNG) exp_l[i] = 1'b1;
      end
`endif
      stable = (s_q.size() >= DBN);
      for (int k = 1; k <= DBN; k++)
        if (stable && s_q[s_q.size()-k][i] == prev[i]) stable = 1'b0;
      if (stable) begin
        exp_o[i] = ~prev[i];
        if (!prev[i]) begin
          exp_p[i]   = 1'b1;
          since_p[i] = 0;
        end else begin
          exp_r[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, compare just after the rising edge.
  task automatic cycle(input logic r, input logic [BW-1:0] b);
    rst   = r;
    btn_i = b;
    #1;
    if (r) begin
      check("rst_o", 32'(btn_o), 32'd0);
      check("rst_p", 32'(btn_p), 32'd0);
      check("rst_r", 32'(btn_r), 32'd0);
      check("rst_l", 32'(btn_l), 32'd0);
    end
    @(posedge clk);
    #1;
    model_step(r, b);
    check("btn_o", 32'(btn_o), 32'(exp_o));
    check("btn_p", 32'(btn_p), 32'(exp_p));
    check("btn_r", 32'(btn_r), 32'(exp_r));
    check("btn_l", 32'(btn_l), 32'(exp_l));
    @(negedge clk);
  endtask

  initial begin
    int            lat;
    int            lcyc;
    int            npulse;
    logic [BW-1:0] cur;
    int            rem [BW];

    for (int i = 0; i < BW; i++) since_p[i] = 0;

    // Reset, then clean press on bit 0: pulse on the 6th edge after sampling.
    cycle(1'b1, 2'b00);
    cycle(1'b1, 2'b00);
    lat = -1;
    npulse = 0;
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b0, 2'b01);
      if (btn_p[0]) npulse++;
      if (lat < 0 && btn_p[0]) lat = n;
    end
    check("press_latency", 32'(lat), 32'd6);
    check("press_pulses", 32'(npulse), 32'd1);

    // Release bit 0.
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b0, 2'b00);
      if (lat < 0 && btn_r[0]) lat = n;
    end
    check("release_latency", 32'(lat), 32'd6);

    // Bounce, then stable press: one pulse only.
    npulse = 0;
    for (int n = 0; n < 8; n++) begin
      cycle(1'b0, {1'b0, ~n[1]});
      if (btn_p[0]) npulse++;
    end
    for (int n = 0; n < 12; n++) begin
      cycle(1'b0, 2'b01);
      if (btn_p[0]) npulse++;
    end
    check("bounce_pulses", 32'(npulse), 32'd1);
    for (int n = 0; n < 10; n++) cycle(1'b0, 2'b00);

    // Glitch on bit 1: 3 cycles high is shorter than the debounce window.
    npulse = 0;
    for (int n = 0; n < 3; n++) cycle(1'b0, 2'b10);
    for (int n = 0; n < 10; n++) begin
      cycle(1'b0, 2'b00);
      if (btn_o[1] || btn_p[1] || btn_r[1]) npulse++;
    end
    check("glitch_quiet", 32'(npulse), 32'd0);

    // Simultaneous press, then reset during a release count with buttons held.
    for (int n = 0; n < 10; n++) cycle(1'b0, 2'b11);
    cycle(1'b0, 2'b00);
    cycle(1'b0, 2'b00);
    cycle(1'b1, 2'b11);
    cycle(1'b1, 2'b11);
    lat = -1;
    npulse = 0;
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b0, 2'b11);
      if (btn_p != 2'b00) npulse++;
      if (lat < 0 && btn_p == 2'b11) lat = n;
    end
    check("rst_rel_latency", 32'(lat), 32'd6);
    check("rst_rel_pulses", 32'(npulse), 32'd1);

    // Long press on bit 0 (bit 1 released first).
    for (int n = 0; n < 10; n++) cycle(1'b0, 2'b00);
    lcyc = -1;
    npulse = 0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      cycle(1'b0, 2'b01);
      if (btn_p[0]) lat = n;
      if (btn_l[0]) begin
        npulse++;
        if (lcyc < 0 && lat >= 0) lcyc = n - lat;
      end
    end
`ifdef BTN_DEBOUNCE_LONG_EN
    check("long_delay", 32'(lcyc), 32'd20);
    check("long_pulses", 32'(npulse), 32'd1);
`else
    check("long_absent", 32'(npulse), 32'd0);
`endif
    for (int n = 0; n < 10; n++) cycle(1'b0, 2'b00);

    // Randomized activity with occasional resets.
    cur = '0;
    for (int i = 0; i < BW; i++) rem[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < BW; i++) begin
        if (rem[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                                : int'($urandom_range(1, 7));
        end
        rem[i]--;
      end
      cycle(($urandom_range(0, 299) == 0), cur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions raw push-button inputs before they reach the stopwatch control inputs (run/stop, clear/split).
- Per button: 2-FF synchronizer, debounce counter, clean level output, and single-cycle press/release pulses.
- The press pulses drive the stopwatch button inputs directly; the level outputs are available for LEDs and other status logic.
- Purely synchronous to the system clock, with asynchronous active-high reset.

Parameters:
- BW, 2, number of buttons handled (bit i is an independent channel).
- DBN, 240_000, debounce time in clock cycles (10 ms at 24 MHz); legal range 2 to 2^24; counter width is clog2(DBN).
- LNG, 24_000_000, long-press time in clock cycles after the debounced press (1 s at 24 MHz); used only with the optional feature.

Ports:
- clk    input   1   system clock, all logic on rising edge
- rst    input   1   reset, asynchronous, active-high; clears all state
- btn_i  input   BW  raw button levels, active-high, asynchronous to clk, may bounce
- btn_o  output  BW  debounced button level
- btn_p  output  BW  press pulse, one cycle, asserted in the cycle btn_o goes 0->1
- btn_r  output  BW  release pulse, one cycle, asserted in the cycle btn_o goes 1->0
- btn_l  output  BW  long-press pulse, one cycle (optional feature, else constant 0)

Behaviour:
- Reset: synchronizer FFs, counters, btn_o, btn_p, btn_r and btn_l all 0, applied immediately on rst rise. Outputs stay 0 while rst is high.
- Synchronizer: two FFs per bit; s = second-stage output. No logic reads btn_i directly.
- Per-bit debounce counter cnt:
  - If s == btn_o: cnt <= 0.
  - If s != btn_o and cnt < DBN-1: cnt <= cnt+1.
  - If s != btn_o and cnt == DBN-1: btn_o <= s and cnt <= 0.
- Latency: a stable raw change first sampled at edge E appears on btn_o at edge E+DBN+1, i.e. DBN+2 edges counting E as edge 1.
- Glitch rejection: any mismatch lasting fewer than DBN consecutive cycles of s leaves btn_o unchanged and clears cnt. A bounce resets the count, so there is no accumulation across bounces.
- Pulses: btn_p and btn_r are registered and valid in the same cycle btn_o changes. They are high for exactly one cycle and never both high on one bit.
- Channels are fully independent; simultaneous presses on several bits produce simultaneous pulses.
- Reset mid-count: cnt is lost. After release from reset with the raw button still held, a full DBN+2 cycles elapse before btn_o=1 and btn_p fires, so a held button at reset release yields a single press pulse.
- No wrap-around: cnt saturates by construction, since it is cleared at DBN-1.

Optional Feature:
- Macro: BTN_DEBOUNCE_LONG_EN.
- Enabled:
  - A per-bit long counter lcnt, clog2(LNG+1) bits, clears whenever btn_o == 0.
  - While btn_o == 1, lcnt increments and saturates at LNG.
  - btn_l pulses for one cycle on the edge lcnt reaches LNG, i.e. LNG cycles after the btn_p cycle.
  - Only one btn_l pulse per press; a new press is required to re-arm.
  - The release pulse btn_r still fires normally after a long press.
- Disabled: lcnt is not instantiated and btn_l is tied to 0.

Test Plan (bench parameters DBN=4, LNG=20, BW=2):
- Reset then clean press: rst high for 2 cycles; btn_i[0] raised and held -> btn_o[0] rises 6 edges after the first sampling edge, with btn_p[0]=1 for exactly that cycle and btn_r=0.
- Bounce: btn_i[0] toggles 1,0,1,0 with 2-cycle periods, then holds 1 -> btn_o[0] stays 0 through the bounce and rises DBN+2 edges after the final stable rise, with one btn_p pulse only.
- Release: btn_i[0] goes 1->0 and holds -> btn_o[0] falls after 6 edges, with btn_r[0] one-cycle pulse and btn_p=0.
- Glitch: btn_i[1] high for 3 cycles only -> btn_o[1], btn_p[1] and btn_r[1] remain 0 throughout.
- Simultaneous and reset mid-count: both bits raised on the same edge -> btn_p=2'b11 in the same cycle. Then rst asserted 2 cycles into a release count -> all outputs 0 immediately; with buttons still held, btn_o=2'b11 again after 6 edges with a single btn_p=2'b11.
- Long press (macro defined): hold btn_i[0] -> btn_l[0] pulses exactly 20 cycles after btn_p[0], once only. With the macro undefined, btn_l stays 2'b00.
